// File: rtl/booth_pkg.sv
// Shared widths, FSM state type and radix-4 Booth digit decoding for the
// carry-save Booth multiplier/accumulator.
package booth_pkg;

  localparam int unsigned OP_W       = 32;
  localparam int unsigned PROD_W     = 64;
  localparam int unsigned NUM_DIGITS = 16;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG2,
    BD_NEG1
  } booth_digit_e;

  // Window is {B[2i+1], B[2i], B[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: decodes one 3-bit window and
// forms the shifted (possibly inverted) 64-bit partial product.
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [2:0]        window,
  input  logic [CNT_W-1:0]  digit_idx,
  output logic [PROD_W-1:0] pp,
  output logic              neg
);

  booth_digit_e      digit;
  logic [PROD_W-1:0] mag1;
  logic [PROD_W-1:0] mag2;
  logic [CNT_W:0]    shamt;

  always_comb begin
    digit = booth_decode(window);
    mag1  = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
    mag2  = mag1 << 1;
    shamt = {digit_idx, 1'b0};
    pp    = '0;
    neg   = 1'b0;
    // Negative digits emit ~mag; the missing +1 is injected by the next step.
    case (digit)
      BD_POS1: pp = mag1 << shamt;
      BD_POS2: pp = mag2 << shamt;
      BD_NEG2: begin
        pp  = (~mag2) << shamt;
        neg = 1'b1;
      end
      BD_NEG1: begin
        pp  = (~mag1) << shamt;
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_csa_accumulator.sv
// Sequential radix-4 Booth multiplier: one digit per clock compressed into a
// carry-save sum/carry pair, final hot-one flushed before the result is offered.
module booth_csa_accumulator
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] sum_vec,
  output logic [PROD_W-1:0] carry_vec
);

  localparam int unsigned FLUSH_POS = 2 * (NUM_DIGITS - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [PROD_W-1:0] sum_q, sum_d;
  logic [PROD_W-1:0] carry_q, carry_d;

  logic [OP_W:0]     b_ext;
  logic [2:0]        window;
  logic [PROD_W-1:0] pp_raw;
  logic              pp_neg;
  logic [CNT_W:0]    hot_pos;
  logic [PROD_W-1:0] hot_run;
  logic [PROD_W-1:0] hot_flush;
  logic [PROD_W-1:0] csa_pp;
  logic [PROD_W-1:0] csa_sum;
  logic [PROD_W-1:0] csa_carry;

  always_comb begin
    b_ext  = {b_q, 1'b0};
    window = b_ext[{cnt_q, 1'b0} +: 3];
  end

  booth_pp_gen u_pp_gen (
    .a         (a_q),
    .window    (window),
    .digit_idx (cnt_q),
    .pp        (pp_raw),
    .neg       (pp_neg)
  );

  // Previous digit's +1 lands at bit 2i-2, which is always zero in this PP.
  always_comb begin
    hot_pos   = {cnt_q - CNT_W'(1), 1'b0};
    hot_run   = PROD_W'(neg_q && (cnt_q != '0)) << hot_pos;
    hot_flush = PROD_W'(neg_q) << FLUSH_POS;
    csa_pp    = (state_q == ST_FLUSH) ? hot_flush : (pp_raw | hot_run);
    csa_sum   = sum_q ^ carry_q ^ csa_pp;
    csa_carry = ((sum_q & carry_q) | (sum_q & csa_pp) | (carry_q & csa_pp)) << 1;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = multiplicand;
          b_d     = multiplier;
          cnt_d   = '0;
          neg_d   = 1'b0;
          sum_d   = '0;
          carry_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = csa_sum;
        carry_d = csa_carry;
        neg_d   = pp_neg;
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        sum_d   = csa_sum;
        carry_d = csa_carry;
        neg_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum_vec   = sum_q;
  assign carry_vec = carry_q;

endmodule
